mii_frame_scheduler: RTL

Sequencing and arbitration controller in front of the 64-bit MII TX frame generator. Round-robin selection among up to N_REQ frame sources, each requesting one frame of a given payload length. For the granted frame the block drives the generator's valid and done strobes for the exact frame duration in 64-bit words, then enforces an inter-packet gap before the next grant.

---
 rtl/mii_sched_pkg.sv | 36 +++
 rtl/mii_rr_arbiter.sv | 50 +++++
 rtl/mii_frame_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mii_sched_pkg.sv
// Shared types and helpers for the MII TX frame scheduler.
// Holds the FSM state encoding, Ethernet framing constants and the
// payload-length to 64-bit-word conversion used at grant time.
package mii_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      SEND,
      DONE,
      IPG
   } state_t;

   // Preamble/SFD 8 + header 14 + FCS 4
   localparam int FRAME_OVERHEAD_BYTES = 26;
   localparam int MIN_PAYLOAD_BYTES    = 46;
   localparam int WORD_BYTES           = 8;

   // Clamp a requested payload into [MIN_PAYLOAD_BYTES, max_len]; short frames are padded
   function automatic logic [15:0] clamp_len(input logic [15:0] len, input int max_len);
      if (int'(len) > max_len)
         return 16'(max_len);
      else if (len < 16'(MIN_PAYLOAD_BYTES))
         return 16'(MIN_PAYLOAD_BYTES);
      else
         return len;
   endfunction

   // Number of 64-bit words on the wire: ceil((overhead + clamped payload) / 8)
   function automatic logic [15:0] frame_words(input logic [15:0] len, input int max_len);
      logic [15:0] l;
      l = clamp_len(len, max_len);
      return (l + 16'(FRAME_OVERHEAD_BYTES + WORD_BYTES - 1)) >> 3;
   endfunction

endpackage

// File: rtl/mii_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick starting at the
// registered pointer, pointer advanced past the winner on each grant.
module mii_rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic             clk,
   input  logic             i_rst,
   input  logic [N_REQ-1:0] i_req,
   input  logic             i_update,
   output logic [N_REQ-1:0] o_pick,
   output logic             o_any
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] win;
   logic             found;

   assign o_any = |i_req;

   // Scan requests starting at the pointer, wrapping, and take the first one set
   always_comb begin
      o_pick = '0;
      win    = '0;
      found  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         for (int j = 0; j < N_REQ; j++) begin
            if (!found && i_req[j] && (j == ((int'(ptr_q) + i) % N_REQ))) begin
               o_pick[j] = 1'b1;
               win       = IDX_W'(j);
               found     = 1'b1;
            end
         end
      end
   end

   // Pointer moves to the source after the winner, only when a grant is taken
   always_ff @(posedge clk) begin
      if (i_rst) begin
         ptr_q <= '0;
      end else if (i_update && o_any) begin
         if (win == IDX_W'(N_REQ - 1))
            ptr_q <= '0;
         else
            ptr_q <= win + 1'b1;
      end
   end

endmodule

// File: rtl/mii_frame_scheduler.sv
// Frame scheduler in front of the 64-bit MII TX generator.
// Grants one source round-robin, drives gen valid for the frame's word
// count, pulses gen done, then holds off for IPG_WORDS idle words.
// Optional statistics counters are enabled by defining MII_SCHED_STATS_EN.
module mii_frame_scheduler
   import mii_sched_pkg::*;
#(
   parameter int N_REQ            = 4,
   parameter int PAYLOAD_MAX_SIZE = 1500,
   parameter int LEN_W            = 11,
   parameter int IPG_WORDS        = 2
) (
   input  logic                   clk,
   input  logic                   i_rst,
   input  logic [N_REQ-1:0]       i_req,
   input  logic [N_REQ*LEN_W-1:0] i_len,
   input  logic                   i_pause,
   output logic [N_REQ-1:0]       o_grant,
   output logic                   o_gen_valid,
   output logic                   o_gen_done,
   output logic [LEN_W-1:0]       o_gen_len,
   output logic                   o_busy
`ifdef MII_SCHED_STATS_EN
   ,
   output logic [15:0]            o_frame_cnt,
   output logic [N_REQ*16-1:0]    o_grant_cnt
`endif
);

   state_t           state_q, state_d;
   logic [15:0]      word_cnt_q, word_cnt_d;
   logic [15:0]      ipg_cnt_q, ipg_cnt_d;
   logic [N_REQ-1:0] pick;
   logic             any_req;
   logic             grant_go;
   logic             start;
   logic [LEN_W-1:0] sel_len;
   logic [15:0]      eff_len;
   logic [15:0]      words;

   logic [N_REQ-1:0] grant_d;
   logic             valid_d;
   logic             done_d;
   logic [LEN_W-1:0] len_d;
   logic             busy_d;

   mii_rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .clk      (clk),
      .i_rst    (i_rst),
      .i_req    (i_req),
      .i_update (start),
      .o_pick   (pick),
      .o_any    (any_req)
   );

   assign grant_go = any_req && !i_pause;

   // Length of the source the arbiter is currently picking, and its frame size
   always_comb begin
      sel_len = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (pick[k])
            sel_len = sel_len | i_len[k*LEN_W +: LEN_W];
      end
      eff_len = clamp_len(16'(sel_len), PAYLOAD_MAX_SIZE);
      words   = frame_words(16'(sel_len), PAYLOAD_MAX_SIZE);
   end

   // Next-state logic plus the values every registered output takes next cycle
   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      ipg_cnt_d  = ipg_cnt_q;
      start      = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant_go) begin
               state_d = GRANT;
               start   = 1'b1;
            end
         end
         GRANT: begin
            state_d = SEND;
         end
         SEND: begin
            if (word_cnt_q == 16'd0)
               state_d = DONE;
            else
               word_cnt_d = word_cnt_q - 16'd1;
         end
         DONE: begin
            state_d   = IPG;
            ipg_cnt_d = 16'(IPG_WORDS - 1);
         end
         IPG: begin
            if (ipg_cnt_q == 16'd0) begin
               if (grant_go) begin
                  state_d = GRANT;
                  start   = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               ipg_cnt_d = ipg_cnt_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // The valid pulse covers W SEND cycles: count W-1 down to 0
      if (start)
         word_cnt_d = words - 16'd1;

      valid_d = (state_d == SEND);
      done_d  = (state_d == DONE);
      busy_d  = (state_d != IDLE);
      len_d   = start ? LEN_W'(eff_len) : o_gen_len;
      if (start)
         grant_d = pick;
      else if (state_d == SEND || state_d == DONE)
         grant_d = o_grant;
      else
         grant_d = '0;
   end

   // State, counters and registered outputs; reset abandons any frame in flight
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         word_cnt_q  <= '0;
         ipg_cnt_q   <= '0;
         o_grant     <= '0;
         o_gen_valid <= 1'b0;
         o_gen_done  <= 1'b0;
         o_gen_len   <= '0;
         o_busy      <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         ipg_cnt_q   <= ipg_cnt_d;
         o_grant     <= grant_d;
         o_gen_valid <= valid_d;
         o_gen_done  <= done_d;
         o_gen_len   <= len_d;
         o_busy      <= busy_d;
      end
   end

`ifdef MII_SCHED_STATS_EN
   // Frame counter steps with each done pulse; per-source counters step on grant
   always_ff @(posedge clk) begin
      if (i_rst) begin
         o_frame_cnt <= '0;
         o_grant_cnt <= '0;
      end else begin
         if (done_d)
            o_frame_cnt <= o_frame_cnt + 16'd1;
         for (int k = 0; k < N_REQ; k++) begin
            if (start && pick[k])
               o_grant_cnt[k*16 +: 16] <= o_grant_cnt[k*16 +: 16] + 16'd1;
         end
      end
   end
`endif

endmodule
